traffic_sequencer: RTL and testbench
====================================

Name: traffic_sequencer

Overview:
- Intersection control FSM and the initiator side of the countdown-timer handshake.
- Selects which programmed interval the timer loads and pulses start_timer on every state entry.
- Advances state on the timer's one-cycle expired pulse and drives main-street, side-street and pedestrian lamps.
- Sits between the parameter register file / timer pair and the lamp drivers. Consumes debounced sensor and walk-button inputs.

Parameters:
- SEL_BASE, 2'b00, selector code for base green interval
- SEL_EXT, 2'b01, selector code for extension / walk interval
- SEL_YEL, 2'b10, selector code for yellow interval

Ports:
- clk  in  1  system clock
- reset_global_n  in  1  asynchronous, active-low reset
- expired  in  1  one-cycle pulse from timer: interval finished
- sensor  in  1  side-street vehicle sensor, asynchronous level
- walk_request  in  1  pedestrian button, asynchronous level
- prog_sync  in  1  one-cycle pulse: parameters reprogrammed, restart cycle
- start_timer  out  1  one-cycle load pulse to timer
- time_param_selector  out  2  interval code to parameter file, valid while start_timer=1
- main_lights  out  3  {red,yellow,green} main street
- side_lights  out  3  {red,yellow,green} side street
- walk_lamp  out  1  pedestrian walk indication
- state_dbg  out  3  current state encoding

Behaviour:
- Clock and reset:
  - All flops use posedge clk and clear asynchronously on reset_global_n=0.
  - Reset values: state=INIT, start_timer=0, time_param_selector=SEL_BASE, main_lights=side_lights=3'b100, walk_lamp=0, walk_pending=0, synchronizer flops=0.
- Input synchronization:
  - sensor and walk_request each pass through 2-flop synchronizers, giving 2 cycles of latency.
  - walk_request is rising-edge detected after synchronization.
  - A detected edge sets walk_pending, except while state=WALK, where edges are ignored.
- States and state_dbg encoding: INIT=0, MG_BASE=1, MG_EXT=2, MG_YEL=3, SG_BASE=4, SG_EXT=5, SG_YEL=6, WALK=7.
- Transitions (every transition except out of INIT is taken only on expired=1):
  - INIT -> MG_BASE unconditionally on the first clock after reset release.
  - MG_BASE -> MG_EXT if sensor_sync=0, else MG_YEL.
  - MG_EXT -> MG_YEL.
  - MG_YEL -> SG_BASE.
  - SG_BASE -> SG_EXT if sensor_sync=1, else SG_YEL.
  - SG_EXT -> SG_YEL.
  - SG_YEL -> WALK if walk_pending=1, else MG_BASE.
  - WALK -> MG_BASE.
- Timer handshake:
  - On the clock edge that enters any non-INIT state, register start_timer=1 for exactly one cycle.
  - In that same cycle, register time_param_selector for the new state: *_BASE -> SEL_BASE, *_EXT -> SEL_EXT, *_YEL -> SEL_YEL, WALK -> SEL_EXT.
  - time_param_selector holds its value until the next state entry.
  - An expired pulse that coincides with start_timer=1 is ignored as stale.
  - expired in INIT is ignored.
  - No transition is taken without expired. A zero-valued parameter hangs the state; the parameter file owns that range check.
- Lamps (registered, updated on the same edge as the state change):
  - MG_BASE / MG_EXT: main 001, side 100.
  - MG_YEL: main 010, side 100.
  - SG_BASE / SG_EXT: main 100, side 001.
  - SG_YEL: main 100, side 010.
  - WALK and INIT: both 100.
  - walk_lamp=1 only in WALK.
- walk_pending:
  - Cleared on entry to WALK.
  - If a new edge and WALK entry coincide, the clear wins.
- prog_sync:
  - In any state, forces the next state to MG_BASE with start_timer=1 and selector SEL_BASE.
  - prog_sync has priority over a simultaneous expired.
  - walk_pending is preserved.
  - prog_sync in INIT also goes to MG_BASE.
- Reset mid-operation: immediate return to INIT values, with no start_timer pulse until the first post-reset edge.

Test Plan:
- Reset release, sensor=0: cycle 1 -> state=1, start_timer=1, selector=00, main=001. Expired -> state=2, selector=01. Next expired -> state=3, selector=10, main=010.
- Sensor=1 held ≥3 cycles before MG_BASE expires: MG_BASE -> MG_YEL (skip EXT). Then SG_BASE -> SG_EXT on expired, side=001 with selector=01.
- Walk_request pulse 5 cycles wide during SG_BASE: walk_pending=1. After SG_YEL expires, state=7, walk_lamp=1, both lights 100, selector=01. Next expired -> MG_BASE, walk_pending=0.
- Expired asserted in the same cycle as start_timer: state unchanged and no second start_timer. Expired one cycle later advances normally.
- Prog_sync in SG_EXT coinciding with expired: next state=1 (not 6), start_timer=1, selector=00, main=001, side=100.
- Reset_global_n pulled low mid-MG_YEL, asynchronous to clk: outputs go to reset values immediately, before the next edge. After release, INIT for 1 cycle then MG_BASE with start_timer pulse.

Source files
------------

// File: rtl/traffic_sequencer_if.sv
// Timer handshake bundle between the traffic sequencer (initiator) and the countdown timer.
// The sequencer requests an interval load; the timer answers with a one-cycle expired pulse.
interface traffic_sequencer_if;
    logic       start_timer;
    logic [1:0] time_param_selector;
    logic       expired;

    modport master (
        output start_timer,
        output time_param_selector,
        input  expired
    );

    modport slave (
        input  start_timer,
        input  time_param_selector,
        output expired
    );
endinterface

// File: rtl/traffic_sequencer.sv
// Intersection control FSM: sequences main/side/walk phases and requests a timer
// interval on every state entry, advancing when the timer reports expiry.
module traffic_sequencer #(
    parameter logic [1:0] SEL_BASE = 2'b00,
    parameter logic [1:0] SEL_EXT  = 2'b01,
    parameter logic [1:0] SEL_YEL  = 2'b10
) (
    input  logic                       clk,
    input  logic                       reset_global_n,
    traffic_sequencer_if.master        tmr,
    input  logic                       sensor,
    input  logic                       walk_request,
    input  logic                       prog_sync,
    output logic [2:0]                 main_lights,
    output logic [2:0]                 side_lights,
    output logic                       walk_lamp,
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        MG_BASE = 3'd1,
        MG_EXT  = 3'd2,
        MG_YEL  = 3'd3,
        SG_BASE = 3'd4,
        SG_EXT  = 3'd5,
        SG_YEL  = 3'd6,
        WALK    = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_t     state_q, state_d;
    logic       start_timer_q, start_timer_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] main_q, main_d;
    logic [2:0] side_q, side_d;
    logic       walk_lamp_q, walk_lamp_d;
    logic       walk_pending_q, walk_pending_d;
    logic       sensor_s1_q, sensor_sync_q;
    logic       walk_s1_q, walk_sync_q, walk_prev_q;
    logic       walk_edge;
    logic       enter;

    function automatic logic [1:0] sel_for(input state_t s);
        case (s)
            MG_EXT, SG_EXT, WALK: sel_for = SEL_EXT;
            MG_YEL, SG_YEL:       sel_for = SEL_YEL;
            default:              sel_for = SEL_BASE;
        endcase
    endfunction

    function automatic logic [2:0] main_for(input state_t s);
        case (s)
            MG_BASE, MG_EXT: main_for = LAMP_GRN;
            MG_YEL:          main_for = LAMP_YEL;
            default:         main_for = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] side_for(input state_t s);
        case (s)
            SG_BASE, SG_EXT: side_for = LAMP_GRN;
            SG_YEL:          side_for = LAMP_YEL;
            default:         side_for = LAMP_RED;
        endcase
    endfunction

    assign walk_edge = walk_sync_q & ~walk_prev_q;

    always_comb begin
        state_d        = state_q;
        enter          = 1'b0;
        if (prog_sync || state_q == INIT) begin
            state_d = MG_BASE;
            enter   = 1'b1;
        end else if (tmr.expired && !start_timer_q) begin
            // An expiry seen while our own load pulse is still out is from the previous interval.
            enter = 1'b1;
            case (state_q)
                MG_BASE: state_d = sensor_sync_q ? MG_YEL : MG_EXT;
                MG_EXT:  state_d = MG_YEL;
                MG_YEL:  state_d = SG_BASE;
                SG_BASE: state_d = sensor_sync_q ? SG_EXT : SG_YEL;
                SG_EXT:  state_d = SG_YEL;
                SG_YEL:  state_d = walk_pending_q ? WALK : MG_BASE;
                default: state_d = MG_BASE;
            endcase
        end

        start_timer_d = enter;
        sel_d         = enter ? sel_for(state_d) : sel_q;
        main_d        = main_for(state_d);
        side_d        = side_for(state_d);
        walk_lamp_d   = (state_d == WALK);

        walk_pending_d = walk_pending_q;
        if (enter && state_d == WALK) begin
            walk_pending_d = 1'b0;
        end else if (walk_edge && state_q != WALK) begin
            walk_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_global_n) begin
        if (!reset_global_n) begin
            state_q        <= INIT;
            start_timer_q  <= 1'b0;
            sel_q          <= SEL_BASE;
            main_q         <= LAMP_RED;
            side_q         <= LAMP_RED;
            walk_lamp_q    <= 1'b0;
            walk_pending_q <= 1'b0;
            sensor_s1_q    <= 1'b0;
            sensor_sync_q  <= 1'b0;
            walk_s1_q      <= 1'b0;
            walk_sync_q    <= 1'b0;
            walk_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_timer_q  <= start_timer_d;
            sel_q          <= sel_d;
            main_q         <= main_d;
            side_q         <= side_d;
            walk_lamp_q    <= walk_lamp_d;
            walk_pending_q <= walk_pending_d;
            sensor_s1_q    <= sensor;
            sensor_sync_q  <= sensor_s1_q;
            walk_s1_q      <= walk_request;
            walk_sync_q    <= walk_s1_q;
            walk_prev_q    <= walk_sync_q;
        end
    end

    assign tmr.start_timer         = start_timer_q;
    assign tmr.time_param_selector = sel_q;
    assign main_lights             = main_q;
    assign side_lights             = side_q;
    assign walk_lamp               = walk_lamp_q;
    assign state_dbg               = state_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer: walks the phase cycle, sensor/walk branches,
// stale-expiry filtering, prog_sync restart and asynchronous reset.
module tb_traffic_sequencer;

    logic       clk;
    logic       reset_global_n;
    logic       sensor;
    logic       walk_request;
    logic       prog_sync;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic [2:0] state_dbg;

    int n_tests;
    int n_fail;

    traffic_sequencer_if bus ();

    traffic_sequencer dut (
        .clk            (clk),
        .reset_global_n (reset_global_n),
        .tmr            (bus.master),
        .sensor         (sensor),
        .walk_request   (walk_request),
        .prog_sync      (prog_sync),
        .main_lights    (main_lights),
        .side_lights    (side_lights),
        .walk_lamp      (walk_lamp),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold expired for the coming posedge; returns at the following negedge.
    task automatic fire_expired();
        bus.expired = 1'b1;
        @(negedge clk);
        bus.expired = 1'b0;
    endtask

    task automatic check_entry(input string tag, input logic [2:0] st, input logic [1:0] sel,
                               input logic [2:0] m, input logic [2:0] s, input logic w);
        check_eq({tag, ".state"}, {5'd0, state_dbg}, {5'd0, st});
        check_eq({tag, ".start"}, {7'd0, bus.start_timer}, 8'd1);
        check_eq({tag, ".sel"},   {6'd0, bus.time_param_selector}, {6'd0, sel});
        check_eq({tag, ".main"},  {5'd0, main_lights}, {5'd0, m});
        check_eq({tag, ".side"},  {5'd0, side_lights}, {5'd0, s});
        check_eq({tag, ".walk"},  {7'd0, walk_lamp}, {7'd0, w});
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ".state"}, {5'd0, state_dbg}, 8'd0);
        check_eq({tag, ".start"}, {7'd0, bus.start_timer}, 8'd0);
        check_eq({tag, ".sel"},   {6'd0, bus.time_param_selector}, 8'd0);
        check_eq({tag, ".main"},  {5'd0, main_lights}, 8'h04);
        check_eq({tag, ".side"},  {5'd0, side_lights}, 8'h04);
        check_eq({tag, ".walk"},  {7'd0, walk_lamp}, 8'd0);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset_global_n = 1'b0;
        sensor         = 1'b0;
        walk_request   = 1'b0;
        prog_sync      = 1'b0;
        bus.expired    = 1'b0;

        tick(3);
        check_reset_vals("rst");
        check_eq("rst.pend", {7'd0, dut.walk_pending_q}, 8'd0);

        // Release between edges; the next posedge leaves INIT.
        reset_global_n = 1'b1;
        tick(1);
        check_entry("mg_base", 3'd1, 2'b00, 3'b001, 3'b100, 1'b0);
        tick(1);
        check_eq("mg_base.start_drop", {7'd0, bus.start_timer}, 8'd0);
        check_eq("mg_base.sel_hold", {6'd0, bus.time_param_selector}, 8'd0);
        fire_expired();
        check_entry("mg_ext", 3'd2, 2'b01, 3'b001, 3'b100, 1'b0);
        tick(1);
        fire_expired();
        check_entry("mg_yel", 3'd3, 2'b10, 3'b010, 3'b100, 1'b0);
        tick(1);
        fire_expired();
        check_entry("sg_base0", 3'd4, 2'b00, 3'b100, 3'b001, 1'b0);
        tick(1);
        fire_expired();
        check_entry("sg_yel0", 3'd6, 2'b10, 3'b100, 3'b010, 1'b0);
        tick(1);
        fire_expired();
        check_entry("no_walk", 3'd1, 2'b00, 3'b001, 3'b100, 1'b0);

        // Sensor present: skip main extension, take side extension.
        sensor = 1'b1;
        tick(3);
        fire_expired();
        check_entry("skip_ext", 3'd3, 2'b10, 3'b010, 3'b100, 1'b0);
        tick(1);
        fire_expired();
        check_entry("sg_base1", 3'd4, 2'b00, 3'b100, 3'b001, 1'b0);

        // Pedestrian press during SG_BASE.
        walk_request = 1'b1;
        tick(5);
        walk_request = 1'b0;
        tick(3);
        check_eq("pend_set", {7'd0, dut.walk_pending_q}, 8'd1);
        check_eq("sg_base1.hold", {5'd0, state_dbg}, 8'd4);
        fire_expired();
        check_entry("sg_ext", 3'd5, 2'b01, 3'b100, 3'b001, 1'b0);

        // prog_sync wins over a coincident expiry.
        tick(1);
        prog_sync   = 1'b1;
        bus.expired = 1'b1;
        @(negedge clk);
        prog_sync   = 1'b0;
        bus.expired = 1'b0;
        check_entry("prog", 3'd1, 2'b00, 3'b001, 3'b100, 1'b0);
        check_eq("prog.pend_kept", {7'd0, dut.walk_pending_q}, 8'd1);

        // Expiry overlapping the load pulse is stale.
        fire_expired();
        check_eq("stale.state", {5'd0, state_dbg}, 8'd1);
        check_eq("stale.start", {7'd0, bus.start_timer}, 8'd0);
        fire_expired();
        check_entry("after_stale", 3'd3, 2'b10, 3'b010, 3'b100, 1'b0);
        tick(1);
        fire_expired();
        check_eq("sg_base2", {5'd0, state_dbg}, 8'd4);
        sensor = 1'b0;
        tick(3);
        fire_expired();
        check_entry("sg_yel2", 3'd6, 2'b10, 3'b100, 3'b010, 1'b0);
        tick(1);
        fire_expired();
        check_entry("walk", 3'd7, 2'b01, 3'b100, 3'b100, 1'b1);
        check_eq("walk.pend_clr", {7'd0, dut.walk_pending_q}, 8'd0);
        tick(1);
        fire_expired();
        check_entry("post_walk", 3'd1, 2'b00, 3'b001, 3'b100, 1'b0);

        // Asynchronous reset in MG_YEL.
        tick(1);
        fire_expired();
        tick(1);
        fire_expired();
        check_eq("mg_yel3", {5'd0, state_dbg}, 8'd3);
        tick(1);
        #2 reset_global_n = 1'b0;
        #1 check_reset_vals("async_rst");
        tick(2);
        #2 reset_global_n = 1'b1;
        #1 check_reset_vals("init_hold");
        tick(1);
        check_entry("rst_mg_base", 3'd1, 2'b00, 3'b001, 3'b100, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
